// File: rtl/hci_mem_bank_responder.sv
// Bank-side responder for NB_BANKS word-interleaved 32-bit TCDM banks: same-cycle grant, byte-enabled writes, one-cycle read response.
// Optional per-bank LFSR stall generator is compiled in with `define HCI_MEM_BANK_RESPONDER_STALL_EN.
module hci_mem_bank_responder #(
  parameter int          NB_BANKS   = 8,
  parameter int          AWM        = 12,
  parameter int          STALL_BITS = 2,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NB_BANKS-1:0]   req_i,
  output logic [NB_BANKS-1:0]   gnt_o,
  input  logic [NB_BANKS*32-1:0] add_i,
  input  logic [NB_BANKS-1:0]   we_n_i,
  input  logic [NB_BANKS*4-1:0] be_i,
  input  logic [NB_BANKS*32-1:0] data_i,
  output logic [NB_BANKS*32-1:0] r_data_o,
  output logic [NB_BANKS-1:0]   r_valid_o
);

  localparam int DEPTH = 1 << AWM;

  logic [NB_BANKS-1:0] w_stall;
  logic [NB_BANKS-1:0] w_gnt;
  logic                w_unused_add;

  // Only the word-select bits of each address are used; the rest are dropped on purpose.
  assign w_unused_add = ^add_i;

  assign w_gnt = req_i & ~w_stall & {NB_BANKS{~rst_i}};
  assign gnt_o = w_gnt;

  for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
    logic [AWM-1:0] w_word;
    logic [31:0]    r_mem [DEPTH];
    logic [31:0]    r_rdata;
    logic           r_valid;

    assign w_word = add_i[b*32+2 +: AWM];

    // Array write port: contents are never reset, and grant already excludes reset cycles.
    always_ff @(posedge clk_i) begin
      if (w_gnt[b] && !we_n_i[b]) begin
        for (int k = 0; k < 4; k++) begin
          if (be_i[b*4+k]) begin
            r_mem[w_word][8*k +: 8] <= data_i[b*32+8*k +: 8];
          end
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_valid <= 1'b0;
        r_rdata <= 32'h0000_0000;
      end else begin
        r_valid <= w_gnt[b];
        if (w_gnt[b] && we_n_i[b]) begin
          r_rdata <= r_mem[w_word];
        end
      end
    end

    assign r_valid_o[b]          = r_valid;
    assign r_data_o[b*32 +: 32]  = r_rdata;

`ifdef HCI_MEM_BANK_RESPONDER_STALL_EN
    localparam logic [15:0] SEED_RAW = LFSR_SEED ^ 16'(b);
    localparam logic [15:0] SEED     = (SEED_RAW == 16'h0000) ? 16'h0001 : SEED_RAW;

    logic [15:0] r_lfsr;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1; free-running so stalls never depend on traffic.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_lfsr <= SEED;
      end else begin
        r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      end
    end

    assign w_stall[b] = (r_lfsr[STALL_BITS-1:0] == '0);
`else
    assign w_stall[b] = 1'b0;
`endif
  end

`ifndef HCI_MEM_BANK_RESPONDER_STALL_EN
  logic w_unused_cfg;
  assign w_unused_cfg = STALL_BITS[0] ^ LFSR_SEED[0];
`endif

endmodule
